// File: rtl/pulse_sequencer.sv
// Programmable multi-phase pulse sequencer: steps through up to NUM_PHASES output
// patterns, each held for a programmable duration, in continuous or burst mode.
module pulse_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 32,
    parameter int OUT_W      = 8,
    parameter int REP_W      = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        mode,
    input  logic [REP_W-1:0]            rep_count,
    input  logic [3:0]                  num_active,
    input  logic [NUM_PHASES*CNT_W-1:0] dur_bus,
    input  logic [NUM_PHASES*OUT_W-1:0] pat_bus,
    input  logic [OUT_W-1:0]            idle_pat,
    output logic [OUT_W-1:0]            signal_out,
    output logic [3:0]                  phase_idx,
    output logic                        busy,
    output logic                        loop_done,
    output logic                        seq_done
);

    // state    | meaning
    // ST_IDLE  | idle_pat driven, waiting for start
    // ST_RUN   | stepping through phases 0..last
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [3:0] MAX_IDX = 4'(NUM_PHASES - 1);

    logic [0:0]       state_q,     state_d;
    logic [OUT_W-1:0] signal_q,    signal_d;
    logic [3:0]       phase_q,     phase_d;
    logic [CNT_W-1:0] timer_q,     timer_d;
    logic [CNT_W-1:0] dur_q,       dur_d;
    logic [REP_W-1:0] loops_q,     loops_d;
    logic [REP_W-1:0] rep_q,       rep_d;
    logic [3:0]       last_q,      last_d;
    logic             mode_q,      mode_d;
    logic             loop_done_q, loop_done_d;
    logic             seq_done_q,  seq_done_d;

    logic [3:0]       next_idx;
    logic [CNT_W-1:0] sel_dur;
    logic [OUT_W-1:0] sel_pat;
    logic [3:0]       eff_last;
    logic [REP_W-1:0] eff_rep;
    logic [REP_W:0]   loops_inc;
    logic             entry;

    always_comb begin
        if ((state_q == ST_IDLE) || (phase_q >= last_q)) begin
            next_idx = 4'd0;
        end else begin
            next_idx = phase_q + 4'd1;
        end
    end

    // Duration and pattern of the phase about to be entered
    always_comb begin
        sel_dur = '0;
        sel_pat = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (next_idx == 4'(i)) begin
                sel_dur = dur_bus[i*CNT_W +: CNT_W];
                sel_pat = pat_bus[i*OUT_W +: OUT_W];
            end
        end
    end

    assign eff_last  = (num_active > MAX_IDX) ? MAX_IDX : num_active;
    assign eff_rep   = (rep_count == '0) ? REP_W'(1) : rep_count;
    assign loops_inc = {1'b0, loops_q} + (REP_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        signal_d    = signal_q;
        phase_d     = phase_q;
        timer_d     = timer_q;
        dur_d       = dur_q;
        loops_d     = loops_q;
        rep_d       = rep_q;
        last_d      = last_q;
        mode_d      = mode_q;
        loop_done_d = 1'b0;
        seq_done_d  = 1'b0;
        entry       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                signal_d = idle_pat;
                phase_d  = 4'd0;
                timer_d  = '0;
                if (start && !abort) begin
                    state_d = ST_RUN;
                    loops_d = '0;
                    entry   = 1'b1;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    signal_d   = idle_pat;
                    phase_d    = 4'd0;
                    timer_d    = '0;
                    seq_done_d = 1'b1;
                end else if (timer_q == dur_q) begin
                    if (phase_q >= last_q) begin
                        loop_done_d = 1'b1;
                        loops_d     = (loops_q == '1) ? loops_q : loops_inc[REP_W-1:0];
                        if (mode_q && (loops_inc >= {1'b0, rep_q})) begin
                            state_d    = ST_IDLE;
                            signal_d   = idle_pat;
                            phase_d    = 4'd0;
                            timer_d    = '0;
                            seq_done_d = 1'b1;
                        end else begin
                            entry = 1'b1;
                        end
                    end else begin
                        entry = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Phase entry snapshots its configuration so mid-phase edits wait for the next entry
        if (entry) begin
            phase_d  = next_idx;
            timer_d  = '0;
            dur_d    = sel_dur;
            signal_d = sel_pat;
            last_d   = eff_last;
            mode_d   = mode;
            rep_d    = eff_rep;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= ST_IDLE;
            signal_q    <= '0;
            phase_q     <= 4'd0;
            timer_q     <= '0;
            dur_q       <= '0;
            loops_q     <= '0;
            rep_q       <= '0;
            last_q      <= 4'd0;
            mode_q      <= 1'b0;
            loop_done_q <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            signal_q    <= signal_d;
            phase_q     <= phase_d;
            timer_q     <= timer_d;
            dur_q       <= dur_d;
            loops_q     <= loops_d;
            rep_q       <= rep_d;
            last_q      <= last_d;
            mode_q      <= mode_d;
            loop_done_q <= loop_done_d;
            seq_done_q  <= seq_done_d;
        end
    end

    assign signal_out = signal_q;
    assign phase_idx  = phase_q;
    assign busy       = (state_q == ST_RUN);
    assign loop_done  = loop_done_q;
    assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed self-checking bench for pulse_sequencer with hand-computed expectations.
module tb_pulse_sequencer;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic         start;
    logic         abort;
    logic         mode;
    logic [15:0]  rep_count;
    logic [3:0]   num_active;
    logic [127:0] dur_bus;
    logic [31:0]  pat_bus;
    logic [7:0]   idle_pat;
    logic [7:0]   signal_out;
    logic [3:0]   phase_idx;
    logic         busy;
    logic         loop_done;
    logic         seq_done;

    int checks   = 0;
    int failures = 0;

    pulse_sequencer dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .rep_count  (rep_count),
        .num_active (num_active),
        .dur_bus    (dur_bus),
        .pat_bus    (pat_bus),
        .idle_pat   (idle_pat),
        .signal_out (signal_out),
        .phase_idx  (phase_idx),
        .busy       (busy),
        .loop_done  (loop_done),
        .seq_done   (seq_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_dur(input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3);
        dur_bus = {d3, d2, d1, d0};
    endtask

    task automatic set_pat(input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
        pat_bus = {p3, p2, p1, p0};
    endtask

    initial begin
        logic [7:0] exp_seq [8];
        int first;
        int pulses;
        exp_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h01, 8'h02, 8'h04, 8'h08};

        rst_n_in   = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        mode       = 1'b0;
        rep_count  = 16'd0;
        num_active = 4'd0;
        dur_bus    = '0;
        pat_bus    = '0;
        idle_pat   = 8'h5A;

        // Reset values
        #2 rst_n_in = 1'b0;
        #1;
        chk("rst_sig", 32'(signal_out), 32'h0);
        chk("rst_phase", 32'(phase_idx), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loop_done", 32'(loop_done), 32'd0);
        chk("rst_seq_done", 32'(seq_done), 32'd0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        chk("idle_after_rst", 32'(signal_out), 32'h5A);
        chk("idle_busy", 32'(busy), 32'd0);

        // Continuous two-phase loop, 41 + 21 cycles
        num_active = 4'd1;
        set_dur(32'd40, 32'd20, 32'd0, 32'd0);
        set_pat(8'h88, 8'h80, 8'h00, 8'h00);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("c_p0_first", 32'(signal_out), 32'h88);
        chk("c_busy", 32'(busy), 32'd1);
        chk("c_phase0", 32'(phase_idx), 32'd0);
        repeat (40) tick();
        chk("c_p0_last", 32'(signal_out), 32'h88);
        tick();
        chk("c_p1_first", 32'(signal_out), 32'h80);
        chk("c_phase1", 32'(phase_idx), 32'd1);
        repeat (20) tick();
        chk("c_p1_last", 32'(signal_out), 32'h80);
        chk("c_no_loop_done", 32'(loop_done), 32'd0);
        tick();
        chk("c_wrap_sig", 32'(signal_out), 32'h88);
        chk("c_wrap_phase", 32'(phase_idx), 32'd0);
        chk("c_wrap_loop_done", 32'(loop_done), 32'd1);
        first  = 0;
        pulses = 0;
        for (int i = 1; i <= 62; i++) begin
            tick();
            if (loop_done) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        chk("c_loop_period", 32'(first), 32'd62);
        chk("c_loop_pulses", 32'(pulses), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_abort_busy", 32'(busy), 32'd0);
        chk("c_abort_seq_done", 32'(seq_done), 32'd1);
        chk("c_abort_sig", 32'(signal_out), 32'h5A);
        tick();
        chk("c_seq_done_once", 32'(seq_done), 32'd0);

        // Burst of two loops over four 1-cycle phases
        num_active = 4'd3;
        set_dur(32'd0, 32'd0, 32'd0, 32'd0);
        set_pat(8'h01, 8'h02, 8'h04, 8'h08);
        mode      = 1'b1;
        rep_count = 16'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("b_sig", 32'(signal_out), 32'(exp_seq[i]));
            chk("b_loop_done", 32'(loop_done), (i == 4) ? 32'd1 : 32'd0);
            chk("b_busy", 32'(busy), 32'd1);
            tick();
        end
        chk("b_end_sig", 32'(signal_out), 32'h5A);
        chk("b_end_busy", 32'(busy), 32'd0);
        chk("b_end_seq_done", 32'(seq_done), 32'd1);
        chk("b_end_loop_done", 32'(loop_done), 32'd1);
        tick();
        chk("b_seq_done_clr", 32'(seq_done), 32'd0);
        chk("b_loop_done_clr", 32'(loop_done), 32'd0);

        // rep_count of zero runs a single loop
        num_active = 4'd1;
        rep_count  = 16'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk("r0_p0", 32'(signal_out), 32'h01);
        tick();
        chk("r0_p1", 32'(signal_out), 32'h02);
        tick();
        chk("r0_idle", 32'(signal_out), 32'h5A);
        chk("r0_seq_done", 32'(seq_done), 32'd1);
        chk("r0_busy", 32'(busy), 32'd0);
        tick();

        // Abort with simultaneous start in cycle 5 of phase 2; start during RUN ignored
        num_active = 4'd3;
        set_dur(32'd1, 32'd2, 32'd10, 32'd0);
        mode  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_phase1_c3", 32'(phase_idx), 32'd1);
        tick();
        chk("a_phase2_c1", 32'(phase_idx), 32'd2);
        chk("a_phase2_sig", 32'(signal_out), 32'h04);
        repeat (4) tick();
        chk("a_phase2_c5", 32'(phase_idx), 32'd2);
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("a_busy", 32'(busy), 32'd0);
        chk("a_sig", 32'(signal_out), 32'h5A);
        chk("a_seq_done", 32'(seq_done), 32'd1);
        chk("a_phase", 32'(phase_idx), 32'd0);
        tick();
        chk("a_seq_done_once", 32'(seq_done), 32'd0);
        chk("a_start_ignored", 32'(busy), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("a_idle_abort_no_pulse", 32'(seq_done), 32'd0);
        chk("a_idle_abort_busy", 32'(busy), 32'd0);

        // num_active beyond NUM_PHASES-1 clamps to phase 3
        num_active = 4'd9;
        set_dur(32'd0, 32'd0, 32'd0, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("n_sig", 32'(signal_out), 32'(exp_seq[i]));
            chk("n_phase", 32'(phase_idx), 32'(i % 4));
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        // Mid-phase duration/pattern edits apply only from the next entry
        num_active = 4'd1;
        set_dur(32'd5, 32'd0, 32'd0, 32'd0);
        set_pat(8'h11, 8'h22, 8'h00, 8'h00);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_dur(32'd1, 32'd0, 32'd0, 32'd0);
        set_pat(8'h33, 8'h22, 8'h00, 8'h00);
        repeat (4) tick();
        chk("m_old_len_phase", 32'(phase_idx), 32'd0);
        chk("m_old_pat", 32'(signal_out), 32'h11);
        tick();
        chk("m_phase1", 32'(phase_idx), 32'd1);
        chk("m_phase1_sig", 32'(signal_out), 32'h22);
        tick();
        chk("m_new_pat", 32'(signal_out), 32'h33);
        tick();
        chk("m_new_len_c2", 32'(phase_idx), 32'd0);
        tick();
        chk("m_new_len_adv", 32'(phase_idx), 32'd1);

        // Asynchronous reset in the middle of a running sequence
        chk("x_busy_before", 32'(busy), 32'd1);
        #3 rst_n_in = 1'b0;
        #1;
        chk("x_sig", 32'(signal_out), 32'h0);
        chk("x_phase", 32'(phase_idx), 32'd0);
        chk("x_busy", 32'(busy), 32'd0);
        chk("x_seq_done", 32'(seq_done), 32'd0);
        chk("x_loop_done", 32'(loop_done), 32'd0);
        tick();
        rst_n_in = 1'b1;
        tick();
        chk("x_idle_pat", 32'(signal_out), 32'h5A);
        chk("x_busy_after", 32'(busy), 32'd0);
        chk("x_no_seq_done", 32'(seq_done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
